steer_sched: RTL and testbench

//  Schedules steering-angle moves for NUM_WHEELS pwm_ctrl rotation channels. Queues per-wheel

---
 rtl/steer_sched_pkg.sv | 24 ++
 rtl/steer_slot.sv | 168 ++++++++++++++++
 rtl/steer_sched.sv | 129 ++++++++++++
 tb/tb_steer_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/steer_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : steer_sched_pkg
// Description : Shared types and constants for the steering-move scheduler.
//               Holds the per-slot state encoding, the angle width used on
//               every pwm_ctrl channel, and a recommended timeout value.
// Revision    : 1.0  initial release
// ============================================================================
package steer_sched_pkg;

  localparam int ANGLE_W     = 12;

  // Recommended value for timeout_cycles when software has no better figure.
  localparam int DEF_TIMEOUT = 1_000_000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PEND   = 2'd1,
    S_ACTIVE = 2'd2,
    S_ABORT  = 2'd3
  } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/steer_slot.sv
`default_nettype none
// ============================================================================
// Module      : steer_slot
// Description : One wheel's move tracker. Holds the pending angle, runs the
//               IDLE/PEND/ACTIVE/ABORT state machine, times the move, arms
//               on a low angle_done so a stale done level is never taken,
//               and holds abort_angle for ABORT_HOLD cycles.
// Ports       : clock, reset         clock / async active-high reset
//               req, req_angle       request strobe and angle for this wheel
//               grant                arbiter grant (comb, this cycle)
//               abort_all            abort active move, drop queued request
//               fail_clear           clear fail_sticky
//               angle_done           done level from pwm_ctrl
//               startup_fail         failure level from pwm_ctrl
//               timeout_cycles       move timeout, 0 disables
//               is_pend              slot waiting for a grant
//               busy                 slot in ACTIVE or ABORT
//               pending              request queued and not yet granted
//               angle_update         1-cycle grant pulse
//               target_angle         angle handed to pwm_ctrl
//               abort_angle          abort to pwm_ctrl
//               done_pulse           1-cycle successful completion
//               fail_sticky          timeout / startup failure flag
// Revision    : 1.0  initial release
// ============================================================================
module steer_slot
  import steer_sched_pkg::*;
#(
  parameter int TMO_W      = 24,
  parameter int ABORT_HOLD = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req,
  input  logic [ANGLE_W-1:0] req_angle,
  input  logic               grant,
  input  logic               abort_all,
  input  logic               fail_clear,
  input  logic               angle_done,
  input  logic               startup_fail,
  input  logic [TMO_W-1:0]   timeout_cycles,
  output logic               is_pend,
  output logic               busy,
  output logic               pending,
  output logic               angle_update,
  output logic [ANGLE_W-1:0] target_angle,
  output logic               abort_angle,
  output logic               done_pulse,
  output logic               fail_sticky
);

  localparam int HOLD_W = (ABORT_HOLD > 1) ? $clog2(ABORT_HOLD) : 1;

  slot_state_t        state;
  logic [ANGLE_W-1:0] pend_angle;
  logic               stored;     // request captured while a move is in flight
  logic               armed;      // angle_done seen low since the grant
  logic [TMO_W-1:0]   timer;
  logic [HOLD_W-1:0]  hold_cnt;

  logic [TMO_W-1:0]   timer_inc;
  logic               timed_out;
  logic               req_take;
  logic               stored_keep;

  // Timer counts completed ACTIVE cycles; the comparison uses the value the
  // current cycle will bring it to, so a move is aborted after exactly
  // timeout_cycles ACTIVE cycles.
  assign timer_inc   = (&timer) ? timer : timer + TMO_W'(1);
  assign timed_out   = (timeout_cycles != '0) && (timer_inc == timeout_cycles);
  assign req_take    = req & ~abort_all;
  assign stored_keep = (stored | req) & ~abort_all;

  assign is_pend = (state == S_PEND);
  assign busy    = (state == S_ACTIVE) || (state == S_ABORT);
  assign pending = is_pend | stored;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      pend_angle   <= '0;
      stored       <= 1'b0;
      armed        <= 1'b0;
      timer        <= '0;
      hold_cnt     <= '0;
      angle_update <= 1'b0;
      target_angle <= '0;
      abort_angle  <= 1'b0;
      done_pulse   <= 1'b0;
      fail_sticky  <= 1'b0;
    end else begin
      angle_update <= 1'b0;
      done_pulse   <= 1'b0;
      // A failure set later in this block overrides the clear.
      if (fail_clear) fail_sticky <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req_take) begin
            pend_angle <= req_angle;
            state      <= S_PEND;
          end
        end

        S_PEND: begin
          if (abort_all) begin
            state <= S_IDLE;
          end else begin
            if (req) pend_angle <= req_angle;
            if (grant) begin
              target_angle <= pend_angle;
              angle_update <= 1'b1;
              state        <= S_ACTIVE;
              timer        <= '0;
              armed        <= 1'b0;
              // A same-cycle request becomes the next queued move.
              stored       <= req;
            end
          end
        end

        S_ACTIVE: begin
          if (req_take) pend_angle <= req_angle;
          if (abort_all) begin
            state       <= S_ABORT;
            abort_angle <= 1'b1;
            hold_cnt    <= '0;
            stored      <= 1'b0;
          end else if (startup_fail) begin
            fail_sticky <= 1'b1;
            state       <= stored_keep ? S_PEND : S_IDLE;
            stored      <= 1'b0;
          end else if (timed_out) begin
            fail_sticky <= 1'b1;
            state       <= S_ABORT;
            abort_angle <= 1'b1;
            hold_cnt    <= '0;
            stored      <= stored_keep;
          end else if (armed && angle_done) begin
            done_pulse <= 1'b1;
            state      <= stored_keep ? S_PEND : S_IDLE;
            stored     <= 1'b0;
          end else begin
            timer  <= timer_inc;
            stored <= stored_keep;
            if (!angle_done) armed <= 1'b1;
          end
        end

        S_ABORT: begin
          if (req_take) pend_angle <= req_angle;
          if (hold_cnt == HOLD_W'(ABORT_HOLD - 1)) begin
            abort_angle <= 1'b0;
            state       <= stored_keep ? S_PEND : S_IDLE;
            stored      <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
            stored   <= stored_keep;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/steer_sched.sv
`default_nettype none
// ============================================================================
// Module      : steer_sched
// Description : Steering-move scheduler for NUM_WHEELS pwm_ctrl channels.
//               Queues per-wheel target angles and grants at most MAX_ACTIVE
//               concurrent moves, one grant per cycle, round-robin.
// Ports       : clock, reset         clock / async active-high reset
//               sched_enable         allow new grants
//               req_valid/req_angle  per-wheel request strobes and angles
//               timeout_cycles       move timeout, 0 disables
//               abort_all            abort active moves, flush queued ones
//               fail_clear           clear fail_sticky
//               angle_done           per-wheel done levels from pwm_ctrl
//               startup_fail         per-wheel failure levels from pwm_ctrl
//               angle_update         per-wheel grant pulses
//               target_angle         per-wheel angles to pwm_ctrl
//               abort_angle          per-wheel aborts to pwm_ctrl
//               pending/busy         per-wheel queue / in-flight status
//               done_pulse           per-wheel completion pulses
//               fail_sticky          per-wheel failure flags
//               active_count         wheels in ACTIVE or ABORT
// Revision    : 1.0  initial release
// ============================================================================
module steer_sched
  import steer_sched_pkg::*;
#(
  parameter int NUM_WHEELS = 4,
  parameter int MAX_ACTIVE = 2,
  parameter int TMO_W      = 24,
  parameter int ABORT_HOLD = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          sched_enable,
  input  logic [NUM_WHEELS-1:0]         req_valid,
  input  logic [ANGLE_W*NUM_WHEELS-1:0] req_angle,
  input  logic [TMO_W-1:0]              timeout_cycles,
  input  logic                          abort_all,
  input  logic                          fail_clear,
  input  logic [NUM_WHEELS-1:0]         angle_done,
  input  logic [NUM_WHEELS-1:0]         startup_fail,
  output logic [NUM_WHEELS-1:0]         angle_update,
  output logic [ANGLE_W*NUM_WHEELS-1:0] target_angle,
  output logic [NUM_WHEELS-1:0]         abort_angle,
  output logic [NUM_WHEELS-1:0]         pending,
  output logic [NUM_WHEELS-1:0]         busy,
  output logic [NUM_WHEELS-1:0]         done_pulse,
  output logic [NUM_WHEELS-1:0]         fail_sticky,
  output logic [2:0]                    active_count
);

  localparam int PTR_W = (NUM_WHEELS > 1) ? $clog2(NUM_WHEELS) : 1;

  logic [NUM_WHEELS-1:0] pend_vec;
  logic [NUM_WHEELS-1:0] grant_vec;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W-1:0]      probe;
  logic                  win_found;
  logic                  grant_ok;
  int                    sum;

  generate
    for (genvar i = 0; i < NUM_WHEELS; i++) begin : g_slot
      steer_slot #(
        .TMO_W      (TMO_W),
        .ABORT_HOLD (ABORT_HOLD)
      ) u_slot (
        .clock          (clock),
        .reset          (reset),
        .req            (req_valid[i]),
        .req_angle      (req_angle[i*ANGLE_W +: ANGLE_W]),
        .grant          (grant_vec[i]),
        .abort_all      (abort_all),
        .fail_clear     (fail_clear),
        .angle_done     (angle_done[i]),
        .startup_fail   (startup_fail[i]),
        .timeout_cycles (timeout_cycles),
        .is_pend        (pend_vec[i]),
        .busy           (busy[i]),
        .pending        (pending[i]),
        .angle_update   (angle_update[i]),
        .target_angle   (target_angle[i*ANGLE_W +: ANGLE_W]),
        .abort_angle    (abort_angle[i]),
        .done_pulse     (done_pulse[i]),
        .fail_sticky    (fail_sticky[i])
      );
    end
  endgenerate

  // Slots in ABORT still count: the motor is still being driven off.
  always_comb begin
    active_count = '0;
    for (int k = 0; k < NUM_WHEELS; k++) begin
      active_count = active_count + {2'b00, busy[k]};
    end
  end

  assign grant_ok = sched_enable && !abort_all && (int'(active_count) < MAX_ACTIVE);

  // Round-robin search: first PEND slot at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    probe     = '0;
    sum       = 0;
    grant_vec = '0;
    for (int k = 0; k < NUM_WHEELS; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NUM_WHEELS) sum = sum - NUM_WHEELS;
      probe = PTR_W'(sum);
      if (!win_found && pend_vec[probe]) begin
        win_found = 1'b1;
        win_idx   = probe;
      end
    end
    if (grant_ok && win_found) grant_vec[win_idx] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_ok && win_found) begin
      rr_ptr <= (win_idx == PTR_W'(NUM_WHEELS - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_steer_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_steer_sched
// Description : Self-checking bench for steer_sched. Directed stimulus pushes
//               expected grants, completions and aborts into queues; a
//               monitor on the falling edge pops and compares them whenever
//               the DUT pulses the matching output.
// Revision    : 1.0  initial release
// ============================================================================
module tb_steer_sched;
  import steer_sched_pkg::*;

  localparam int NW   = 4;
  localparam int MAXA = 2;
  localparam int TW   = 24;
  localparam int HOLD = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              sched_enable;
  logic [NW-1:0]     req_valid;
  logic [12*NW-1:0]  req_angle;
  logic [TW-1:0]     timeout_cycles;
  logic              abort_all;
  logic              fail_clear;
  logic [NW-1:0]     angle_done;
  logic [NW-1:0]     startup_fail;
  logic [NW-1:0]     angle_update;
  logic [12*NW-1:0]  target_angle;
  logic [NW-1:0]     abort_angle;
  logic [NW-1:0]     pending;
  logic [NW-1:0]     busy;
  logic [NW-1:0]     done_pulse;
  logic [NW-1:0]     fail_sticky;
  logic [2:0]        active_count;

  steer_sched #(
    .NUM_WHEELS (NW),
    .MAX_ACTIVE (MAXA),
    .TMO_W      (TW),
    .ABORT_HOLD (HOLD)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .sched_enable   (sched_enable),
    .req_valid      (req_valid),
    .req_angle      (req_angle),
    .timeout_cycles (timeout_cycles),
    .abort_all      (abort_all),
    .fail_clear     (fail_clear),
    .angle_done     (angle_done),
    .startup_fail   (startup_fail),
    .angle_update   (angle_update),
    .target_angle   (target_angle),
    .abort_angle    (abort_angle),
    .pending        (pending),
    .busy           (busy),
    .done_pulse     (done_pulse),
    .fail_sticky    (fail_sticky),
    .active_count   (active_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         wheel;
    logic [11:0] angle;
  } grant_t;

  grant_t exp_grant[$];
  int     exp_done[$];
  int     exp_abort[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // ---------------- monitor / scoreboard ----------------
  grant_t        mon_g;
  int            mon_w;
  int            abort_len[NW];
  logic [NW-1:0] abort_prev = '0;
  int            max_cnt    = 0;

  always @(negedge clock) begin
    if (reset) begin
      abort_prev = '0;
      for (int i = 0; i < NW; i++) abort_len[i] = 0;
    end else begin
      if (int'(active_count) > max_cnt) max_cnt = int'(active_count);
      for (int w = 0; w < NW; w++) begin
        if (angle_update[w]) begin
          if (exp_grant.size() == 0) chk("grant_unexpected_wheel", w, 64'hFF);
          else begin
            mon_g = exp_grant.pop_front();
            chk("grant_wheel", w, mon_g.wheel);
            chk("grant_angle", target_angle[w*12 +: 12], mon_g.angle);
          end
        end
        if (done_pulse[w]) begin
          if (exp_done.size() == 0) chk("done_unexpected_wheel", w, 64'hFF);
          else begin
            mon_w = exp_done.pop_front();
            chk("done_wheel", w, mon_w);
          end
        end
        if (abort_angle[w] && !abort_prev[w]) begin
          if (exp_abort.size() == 0) chk("abort_unexpected_wheel", w, 64'hFF);
          else begin
            mon_w = exp_abort.pop_front();
            chk("abort_wheel", w, mon_w);
          end
        end
        if (abort_angle[w]) abort_len[w]++;
        else if (abort_prev[w]) begin
          chk("abort_hold_len", abort_len[w], HOLD);
          abort_len[w] = 0;
        end
      end
      abort_prev = abort_angle;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_req(input logic [NW-1:0] mask, input logic [12*NW-1:0] angles);
    req_valid = mask;
    req_angle = angles;
    tick();
    req_valid = '0;
  endtask

  task automatic push_grant(input int w, input logic [11:0] a);
    grant_t g;
    g.wheel = w;
    g.angle = a;
    exp_grant.push_back(g);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_grant.size() + exp_done.size() + exp_abort.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, exp_grant.size() + exp_done.size() + exp_abort.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    sched_enable   = 1'b0;
    req_valid      = '0;
    req_angle      = '0;
    timeout_cycles = '0;
    abort_all      = 1'b0;
    fail_clear     = 1'b0;
    angle_done     = '0;
    startup_fail   = '0;
    tick();
    tick();
    chk("rst_update",  angle_update, 0);
    chk("rst_target",  target_angle, 0);
    chk("rst_busy",    busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_count",   active_count, 0);
    reset        = 1'b0;
    sched_enable = 1'b1;
    tick();

    // ---- 1: reset while a move is active ----
    push_grant(0, 12'h123);
    send_req(4'b0001, {36'h0, 12'h123});
    tick();                       // grant pulse
    tick();                       // w0 ACTIVE
    chk("t1_busy_pre", busy, 4'b0001);
    reset = 1'b1;
    #1;
    chk("t1_rst_busy",   busy, 0);
    chk("t1_rst_target", target_angle, 0);
    chk("t1_rst_abort",  abort_angle, 0);
    tick();
    tick();
    chk("t1_rst_abort_hold", abort_angle, 0);
    reset = 1'b0;
    tick();

    // ---- 2: four requests, two at a time ----
    push_grant(0, 12'h010);
    push_grant(1, 12'h020);
    send_req(4'b1111, {12'h040, 12'h030, 12'h020, 12'h010});
    chk("t2_pending", pending, 4'b1111);
    tick();
    chk("t2_upd_w0", angle_update, 4'b0001);
    chk("t2_cnt1",   active_count, 1);
    tick();
    chk("t2_upd_w1", angle_update, 4'b0010);
    chk("t2_cnt2",   active_count, 2);
    chk("t2_pend2",  pending, 4'b1100);
    tick();
    chk("t2_no_third", angle_update, 0);
    exp_done.push_back(0);
    push_grant(2, 12'h030);
    angle_done[0] = 1'b1;
    tick();
    angle_done[0] = 1'b0;
    chk("t2_done0",  done_pulse, 4'b0001);
    chk("t2_cnt_dn", active_count, 1);
    tick();
    chk("t2_upd_w2", angle_update, 4'b0100);
    chk("t2_pend3",  pending, 4'b1000);
    exp_done.push_back(1);
    push_grant(3, 12'h040);
    angle_done[1] = 1'b1;
    tick();
    angle_done[1] = 1'b0;
    tick();
    chk("t2_upd_w3", angle_update, 4'b1000);
    tick();
    exp_done.push_back(2);
    exp_done.push_back(3);
    angle_done[3:2] = 2'b11;
    tick();
    angle_done[3:2] = 2'b00;
    chk("t2_done23", done_pulse, 4'b1100);
    tick();
    chk("t2_idle", busy, 0);
    drain("t2_drain", 20);

    // ---- 3: stale done level is ignored ----
    angle_done[0] = 1'b1;
    push_grant(0, 12'h0AB);
    send_req(4'b0001, {36'h0, 12'h0AB});
    tick();
    repeat (5) tick();
    chk("t3_no_done", done_pulse, 0);
    chk("t3_busy",    busy, 4'b0001);
    angle_done[0] = 1'b0;
    tick();
    exp_done.push_back(0);
    angle_done[0] = 1'b1;
    tick();
    angle_done[0] = 1'b0;
    chk("t3_done", done_pulse, 4'b0001);
    drain("t3_drain", 10);

    // ---- 4: timeout ----
    timeout_cycles = 24'd100;
    push_grant(1, 12'h0CC);
    exp_abort.push_back(1);
    send_req(4'b0010, {24'h0, 12'h0CC, 12'h0});
    tick();                       // grant edge
    repeat (99) tick();
    chk("t4_no_abort_yet", abort_angle, 0);
    tick();
    chk("t4_abort",   abort_angle, 4'b0010);
    chk("t4_fail",    fail_sticky, 4'b0010);
    chk("t4_cnt",     active_count, 1);
    repeat (3) tick();
    chk("t4_abort_hold", abort_angle, 4'b0010);
    tick();
    chk("t4_abort_end", abort_angle, 0);
    chk("t4_idle",      busy, 0);
    chk("t4_fail_kept", fail_sticky, 4'b0010);
    fail_clear = 1'b1;
    tick();
    fail_clear = 1'b0;
    chk("t4_fail_clr", fail_sticky, 0);
    timeout_cycles = '0;
    drain("t4_drain", 10);

    // ---- 5: request while the wheel is moving ----
    push_grant(1, 12'h0DD);
    send_req(4'b0010, {24'h0, 12'h0DD, 12'h0});
    tick();
    tick();
    exp_done.push_back(1);
    push_grant(1, 12'h100);
    send_req(4'b0010, {24'h0, 12'h100, 12'h0});
    chk("t5_stored", pending, 4'b0010);
    angle_done[1] = 1'b1;
    tick();
    angle_done[1] = 1'b0;
    tick();
    chk("t5_regrant", angle_update, 4'b0010);
    chk("t5_target",  target_angle[23:12], 12'h100);
    tick();
    exp_done.push_back(1);
    angle_done[1] = 1'b1;
    tick();
    angle_done[1] = 1'b0;
    drain("t5_drain", 10);

    // ---- 6: abort_all with two active, two pending ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    push_grant(0, 12'h111);
    push_grant(1, 12'h222);
    exp_abort.push_back(0);
    exp_abort.push_back(1);
    send_req(4'b1111, {12'h444, 12'h333, 12'h222, 12'h111});
    tick();
    tick();
    tick();
    chk("t6_pre_busy", busy, 4'b0011);
    abort_all = 1'b1;
    req_valid = 4'b0001;
    req_angle = {36'h0, 12'h555};
    tick();
    abort_all = 1'b0;
    req_valid = '0;
    chk("t6_abort",   abort_angle, 4'b0011);
    chk("t6_busy",    busy, 4'b0011);
    chk("t6_pending", pending, 0);
    chk("t6_fail",    fail_sticky, 0);
    repeat (6) tick();
    chk("t6_idle",     busy, 0);
    chk("t6_cnt",      active_count, 0);
    chk("t6_no_grant", pending, 0);
    drain("t6_drain", 10);

    chk("max_active_count", max_cnt, MAXA);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
